// File: rtl/wbs_decoder.sv
// Single-master to multi-slave Wishbone fan-out: decodes the address against
// per-slave inclusive ranges, holds the chosen slave's strobe until it responds
// or times out, and returns a one-cycle registered ack/err.
module wbs_decoder #(
    parameter int                          NUM_SLAVES      = 4,
    parameter logic [32*NUM_SLAVES-1:0]    SLAVE_BASE      = {32'h0003_0000, 32'h0002_0000,
                                                              32'h0001_0000, 32'h0000_0000},
    parameter logic [32*NUM_SLAVES-1:0]    SLAVE_HIGH      = {32'h0003_FFFF, 32'h0002_FFFF,
                                                              32'h0001_FFFF, 32'h0000_FFFF},
    parameter int                          TIMEOUT         = 1024,
    parameter int                          NUM_SLAVES_BITS = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_ni,
    input  logic                         wbm_cyc_i,
    input  logic                         wbm_stb_i,
    input  logic                         wbm_we_i,
    input  logic [1:0]                   wbm_sel_i,
    input  logic [31:0]                  wbm_adr_i,
    input  logic [15:0]                  wbm_dat_i,
    output logic [15:0]                  wbm_dat_o,
    output logic                         wbm_ack_o,
    output logic                         wbm_err_o,
    output logic [NUM_SLAVES-1:0]        wbs_cyc_o,
    output logic [NUM_SLAVES-1:0]        wbs_stb_o,
    output logic                         wbs_we_o,
    output logic [1:0]                   wbs_sel_o,
    output logic [31:0]                  wbs_adr_o,
    output logic [15:0]                  wbs_dat_o,
    input  logic [16*NUM_SLAVES-1:0]     wbs_dat_i,
    input  logic [NUM_SLAVES-1:0]        wbs_ack_i,
    input  logic [NUM_SLAVES-1:0]        wbs_err_i,
    output logic [NUM_SLAVES_BITS-1:0]   wbs_id,
    output logic                         timeout_o
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_RESP
    } state_t;

    state_t                state, next_state;
    logic [CNT_W-1:0]      cnt;
    logic                  hit;
    logic [NUM_SLAVES_BITS-1:0] hit_id;
    logic                  sel_ack, sel_err;
    logic [15:0]           sel_dat;
    logic                  do_accept, do_ack, do_err, do_timeout;

    // Scan from the top down so the lowest matching index overrides the rest.
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        hit    = 1'b0;
        hit_id = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (wbm_adr_i >= SLAVE_BASE[32*i +: 32] && wbm_adr_i <= SLAVE_HIGH[32*i +: 32]) begin
                hit    = 1'b1;
                hit_id = NUM_SLAVES_BITS'(i);
            end
        end
    end

    always_comb begin
        sel_ack = 1'b0;
        sel_err = 1'b0;
        sel_dat = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (wbs_id == NUM_SLAVES_BITS'(i)) begin
                sel_ack = wbs_ack_i[i];
                sel_err = wbs_err_i[i];
                sel_dat = wbs_dat_i[16*i +: 16];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state <= ST_IDLE;
        else            state <= next_state;
    end

    always_comb begin
        next_state = state;
        do_accept  = 1'b0;
        do_ack     = 1'b0;
        do_err     = 1'b0;
        do_timeout = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (wbm_cyc_i && wbm_stb_i) begin
                    do_accept = 1'b1;
                    if (hit) begin
                        next_state = ST_ACTIVE;
                    end else begin
                        do_err     = 1'b1;
                        next_state = ST_RESP;
                    end
                end
            end
            ST_ACTIVE: begin
                // err beats ack, and any response beats the timeout on the same edge.
                if (sel_err) begin
                    do_err     = 1'b1;
                    next_state = ST_RESP;
                end else if (sel_ack) begin
                    do_ack     = 1'b1;
                    next_state = ST_RESP;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    do_err     = 1'b1;
                    do_timeout = 1'b1;
                    next_state = ST_RESP;
                end
            end
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbm_ack_o <= 1'b0;
            wbm_err_o <= 1'b0;
            timeout_o <= 1'b0;
            wbm_dat_o <= '0;
            wbs_we_o  <= 1'b0;
            wbs_sel_o <= '0;
            wbs_adr_o <= '0;
            wbs_dat_o <= '0;
            wbs_id    <= '0;
            cnt       <= '0;
        end else begin
            wbm_ack_o <= do_ack;
            wbm_err_o <= do_err;
            timeout_o <= do_timeout;
            if (do_accept) begin
                wbs_we_o  <= wbm_we_i;
                wbs_sel_o <= wbm_sel_i;
                wbs_adr_o <= wbm_adr_i;
                wbs_dat_o <= wbm_dat_i;
                if (hit) begin
                    wbs_id <= hit_id;
                    cnt    <= '0;
                end
            end
            if (state == ST_ACTIVE) cnt <= cnt + CNT_W'(1);
            if (do_ack)             wbm_dat_o <= sel_dat;
        end
    end

    // Strobes decode straight from state so an asynchronous reset drops them at once.
    always_comb begin
        wbs_cyc_o = '0;
        if (state == ST_ACTIVE) wbs_cyc_o[wbs_id] = 1'b1;
    end

    assign wbs_stb_o = wbs_cyc_o;

endmodule

// File: tb/tb_wbs_decoder.sv
// Scoreboard bench for wbs_decoder: each request pushes its expected response,
// which is popped and compared when the master-side ack/err appears.
module tb_wbs_decoder;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni;
    logic        wbm_cyc_i, wbm_stb_i, wbm_we_i;
    logic [1:0]  wbm_sel_i;
    logic [31:0] wbm_adr_i;
    logic [15:0] wbm_dat_i;
    logic [15:0] wbm_dat_o;
    logic        wbm_ack_o, wbm_err_o;
    logic [3:0]  wbs_cyc_o, wbs_stb_o;
    logic        wbs_we_o;
    logic [1:0]  wbs_sel_o;
    logic [31:0] wbs_adr_o;
    logic [15:0] wbs_dat_o;
    logic [63:0] wbs_dat_i;
    logic [3:0]  wbs_ack_i, wbs_err_i;
    logic [1:0]  wbs_id;
    logic        timeout_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_err;
        bit          is_to;
        logic [15:0] dat;
        int          id;
        int          strobes;
        int          lat;
    } exp_t;

    exp_t sb[$];

    wbs_decoder dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .wbm_cyc_i (wbm_cyc_i),
        .wbm_stb_i (wbm_stb_i),
        .wbm_we_i  (wbm_we_i),
        .wbm_sel_i (wbm_sel_i),
        .wbm_adr_i (wbm_adr_i),
        .wbm_dat_i (wbm_dat_i),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_o (wbm_ack_o),
        .wbm_err_o (wbm_err_o),
        .wbs_cyc_o (wbs_cyc_o),
        .wbs_stb_o (wbs_stb_o),
        .wbs_we_o  (wbs_we_o),
        .wbs_sel_o (wbs_sel_o),
        .wbs_adr_o (wbs_adr_o),
        .wbs_dat_o (wbs_dat_o),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_i (wbs_ack_i),
        .wbs_err_i (wbs_err_i),
        .wbs_id    (wbs_id),
        .timeout_o (timeout_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called positioned at a negedge. rc is the strobe cycle on which slave rs
    // responds (0 = never); noise >= 0 names a slave that acks every strobe cycle.
    task automatic run_txn(input logic [31:0] adr, input logic we, input logic [1:0] sel,
                           input logic [15:0] wdat, input int rs, input int rc,
                           input bit r_ack, input bit r_err, input logic [15:0] rdat,
                           input int noise, input exp_t e);
        int   lat;
        int   strobes;
        bit   done;
        exp_t got;
        lat = 0; strobes = 0; done = 0;
        wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
        wbm_we_i  = we;   wbm_sel_i = sel;
        wbm_adr_i = adr;  wbm_dat_i = wdat;
        sb.push_back(e);
        while (!done && lat < 3000) begin
            @(negedge wb_clk_i);
            lat++;
            wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
            wbm_adr_i = $urandom; wbm_dat_i = 16'($urandom);
            wbm_we_i  = 1'($urandom); wbm_sel_i = 2'($urandom);
            wbs_ack_i = '0; wbs_err_i = '0;
            if (wbm_ack_o || wbm_err_o) begin
                done = 1;
                check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    check("resp_ack", 32'(wbm_ack_o), 32'(!got.is_err));
                    check("resp_err", 32'(wbm_err_o), 32'(got.is_err));
                    check("resp_timeout", 32'(timeout_o), 32'(got.is_to));
                    check("resp_latency", 32'(lat), 32'(got.lat));
                    check("strobe_cycles", 32'(strobes), 32'(got.strobes));
                    check("cyc_in_resp", 32'(wbs_cyc_o), 32'd0);
                    if (!got.is_err) check("read_data", 32'(wbm_dat_o), 32'(got.dat));
                    if (got.strobes > 0) check("resp_id", 32'(wbs_id), 32'(got.id));
                end
            end else if (wbs_cyc_o != '0) begin
                strobes++;
                if (strobes == 1) begin
                    check("cyc_onehot", 32'(wbs_cyc_o), 32'(4'b0001 << e.id));
                    check("stb_eq_cyc", 32'(wbs_stb_o), 32'(wbs_cyc_o));
                    check("latched_adr", wbs_adr_o, adr);
                    check("latched_we", 32'(wbs_we_o), 32'(we));
                    check("latched_sel", 32'(wbs_sel_o), 32'(sel));
                    check("latched_dat", 32'(wbs_dat_o), 32'(wdat));
                    check("slave_id", 32'(wbs_id), 32'(e.id));
                end
                if (noise >= 0) begin
                    wbs_ack_i[noise] = 1'b1;
                    wbs_dat_i[16*noise +: 16] = 16'hDEAD;
                end
                if (strobes == rc) begin
                    wbs_ack_i[rs] = r_ack;
                    wbs_err_i[rs] = r_err;
                    wbs_dat_i[16*rs +: 16] = rdat;
                end
            end
        end
        if (!done) begin
            check("resp_bound", 32'd0, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
        end
        @(negedge wb_clk_i);
        check("pulse_one_cycle", 32'({wbm_ack_o, wbm_err_o, timeout_o}), 32'd0);
        check("cyc_after_resp", 32'(wbs_cyc_o), 32'd0);
    endtask

    function automatic exp_t mk(bit is_err, bit is_to, logic [15:0] dat, int id, int strobes, int lat);
        exp_t e;
        e.is_err = is_err; e.is_to = is_to; e.dat = dat;
        e.id = id; e.strobes = strobes; e.lat = lat;
        return e;
    endfunction

    initial begin
        wb_rst_ni = 1'b0;
        wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0; wbm_we_i = 1'b0;
        wbm_sel_i = '0;   wbm_adr_i = '0;   wbm_dat_i = '0;
        wbs_dat_i = '0;   wbs_ack_i = '0;   wbs_err_i = '0;
        repeat (2) @(negedge wb_clk_i);
        check("rst_cyc", 32'(wbs_cyc_o), 32'd0);
        check("rst_pulses", 32'({wbm_ack_o, wbm_err_o, timeout_o}), 32'd0);
        check("rst_dat", 32'(wbm_dat_o), 32'd0);
        check("rst_latched", 32'({wbs_we_o, wbs_sel_o, wbs_dat_o}), 32'd0);
        check("rst_adr", wbs_adr_o, 32'd0);
        check("rst_id", 32'(wbs_id), 32'd0);
        wb_rst_ni = 1'b1;
        @(negedge wb_clk_i);

        // Read hit, slave 2 acks on its second strobe cycle.
        run_txn(32'h0002_0010, 1'b0, 2'b11, 16'h0000, 2, 2, 1, 0, 16'hBEEF, -1, mk(0, 0, 16'hBEEF, 2, 2, 3));
        // Write hit, zero-wait slave 0 (data captured even on write acks).
        run_txn(32'h0000_0004, 1'b1, 2'b11, 16'h1234, 0, 1, 1, 0, 16'h5555, -1, mk(0, 0, 16'h5555, 0, 1, 2));
        // Unmapped address.
        run_txn(32'h0010_0000, 1'b0, 2'b01, 16'h0000, 0, 0, 0, 0, 16'h0000, -1, mk(1, 0, 16'h0000, 0, 0, 1));
        // Slave 1 never responds.
        run_txn(32'h0001_0000, 1'b0, 2'b10, 16'h0000, 1, 0, 0, 0, 16'h0000, -1, mk(1, 1, 16'h0000, 1, 1024, 1025));
        // Slave 3 acks and errs together.
        run_txn(32'h0003_0004, 1'b1, 2'b01, 16'h7777, 3, 1, 1, 1, 16'h1111, -1, mk(1, 0, 16'h0000, 3, 1, 2));
        // Slave 0 acks every cycle while slave 3 is selected.
        run_txn(32'h0003_1000, 1'b0, 2'b11, 16'h0000, 3, 3, 1, 0, 16'h3333, 0, mk(0, 0, 16'h3333, 3, 3, 4));
        // Response on the last allowed cycle beats the timeout.
        run_txn(32'h0001_FFFF, 1'b0, 2'b11, 16'h0000, 1, 1024, 1, 0, 16'hA5A5, -1, mk(0, 0, 16'hA5A5, 1, 1024, 1025));
        // Range boundaries.
        run_txn(32'h0000_FFFF, 1'b0, 2'b11, 16'h0000, 0, 1, 1, 0, 16'h0F0F, -1, mk(0, 0, 16'h0F0F, 0, 1, 2));
        run_txn(32'h0004_0000, 1'b0, 2'b11, 16'h0000, 0, 0, 0, 0, 16'h0000, -1, mk(1, 0, 16'h0000, 0, 0, 1));

        // Asynchronous reset in the middle of an ACTIVE transaction.
        wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1; wbm_we_i = 1'b0;
        wbm_sel_i = 2'b11; wbm_adr_i = 32'h0001_0020; wbm_dat_i = '0;
        @(negedge wb_clk_i);
        wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        check("pre_reset_cyc", 32'(wbs_cyc_o), 32'b0010);
        #2 wb_rst_ni = 1'b0;
        #1;
        check("async_rst_cyc", 32'(wbs_cyc_o), 32'd0);
        check("async_rst_pulses", 32'({wbm_ack_o, wbm_err_o, timeout_o}), 32'd0);
        check("async_rst_adr", wbs_adr_o, 32'd0);
        repeat (2) @(negedge wb_clk_i);
        check("in_rst_pulses", 32'({wbm_ack_o, wbm_err_o, timeout_o}), 32'd0);
        wb_rst_ni = 1'b1;
        @(negedge wb_clk_i);
        check("post_rst_pulses", 32'({wbm_ack_o, wbm_err_o, timeout_o}), 32'd0);
        run_txn(32'h0003_0000, 1'b0, 2'b11, 16'h0000, 3, 1, 1, 0, 16'hCAFE, -1, mk(0, 0, 16'hCAFE, 3, 1, 2));

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
